// File: rtl/serial_decoder_adder.sv
// serial_decoder_adder
//   Multi-cycle add/subtract unit. Each clock it pushes BPC bit-slices (LSB first) through a
//   chain of decoder-based full-adder cells; the carry is registered between steps.
//   Ports:
//     clk, rst_n         rising-edge clock, asynchronous active-low reset
//     start              request, sampled only while idle
//     sub                0: a + b + ci, 1: a - b (ci ignored)
//     a, b, ci           operands and carry-in, captured when start is accepted
//     busy, done         busy while running/completing; done is a one-cycle pulse
//     sum, co, ovf       result, carry-out of MSB, signed overflow; updated only at completion
module serial_decoder_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned STEPS = WIDTH / BPC;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned PW    = (STEPS > 1) ? (WIDTH - BPC) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(STEPS - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_decoder_adder: WIDTH must be >= 2");
  end
  if ((WIDTH % BPC) != 0) begin : g_bad_bpc
    $error("serial_decoder_adder: BPC must divide WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_psum;
  logic [WIDTH-1:0] r_sum;
  logic             r_co, r_ovf;

  logic [BPC:0]     w_c;
  logic [BPC-1:0]   w_s;
  logic [WIDTH-1:0] w_psum_nxt;
  logic [PW-1:0]    w_psum_keep;
  logic             w_last;

  assign w_c[0] = r_carry;
  assign w_last = (r_cnt == LastCnt);

  // Decoder-based full-adder cells, rippled combinationally within one step.
  for (genvar i = 0; i < BPC; i++) begin : g_cell
    logic [2:0] w_sel;
    // Active-low minterm lines; Y0 feeds neither output so it is not built.
    logic [7:1] w_y;
    assign w_sel = {r_a[i], r_b[i], w_c[i]};
    for (genvar k = 1; k < 8; k++) begin : g_dec
      assign w_y[k] = ~(w_sel == 3'(k));
    end
    assign w_s[i]   = ~(w_y[1] & w_y[2] & w_y[4] & w_y[7]);
    assign w_c[i+1] = ~(w_y[3] & w_y[5] & w_y[6] & w_y[7]);
  end

  // New sum bits enter at the top; after the last step the register holds the full result.
  if (STEPS > 1) begin : g_psum
    assign w_psum_nxt  = {w_s, r_psum};
    assign w_psum_keep = w_psum_nxt[WIDTH-1:BPC];
  end else begin : g_psum_single
    assign w_psum_nxt  = w_s;
    assign w_psum_keep = '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_nxt = StRun;
      StRun:   if (w_last) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a     <= a;
            // Subtract as a + ~b + 1.
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : ci;
            r_cnt   <= '0;
          end
        end
        StRun: begin
          r_a     <= r_a >> BPC;
          r_b     <= r_b >> BPC;
          r_carry <= w_c[BPC];
          r_psum  <= w_psum_keep;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum <= w_psum_nxt;
            r_co  <= w_c[BPC];
            // Carry into the MSB cell vs. carry out of it.
            r_ovf <= w_c[BPC] ^ w_c[BPC-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != StIdle);
  assign done = (r_state == StDone);
  assign sum  = r_sum;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule
